// File: rtl/rd53_afe_tot_array.sv
// RD53 front-end channel array: calibration injection, per-channel ToT counters, strobed latch, delay line.
// Optional feature macro AFE_TOT_PILEUP_EN: injections on a busy channel add to the running ToT.

module rd53_afe_tot_array #(
    parameter int unsigned NCH          = 8,
    parameter int unsigned DAC_W        = 12,
    parameter int unsigned TOT_W        = 8,
    parameter int unsigned DELAY_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [NCH-1:0]   PIXEL_IN,
    input  logic [NCH-1:0]   S0,
    input  logic [NCH-1:0]   S1,
    input  logic [DAC_W-1:0] CAL_HI,
    input  logic [DAC_W-1:0] CAL_MI,
    input  logic [2:0]       IDISCH_SHIFT,
    input  logic [NCH-1:0]   POWER_DOWN,
    input  logic             PHI_AZ,
    input  logic             STROBE,
    input  logic             DELAY_IN,
    output logic             DELAY_OUT,
    output logic [NCH-1:0]   VOUTP,
    output logic [NCH-1:0]   VOUTN,
    output logic [NCH-1:0]   TOT_BUSY
);

    localparam int unsigned SUM_W = DAC_W + 1;
    localparam int unsigned CMP_W = (SUM_W > TOT_W) ? SUM_W : TOT_W + 1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    logic [NCH-1:0]          s0_q;
    logic [NCH-1:0]          s1_q;
    logic [NCH-1:0]          e0;
    logic [NCH-1:0]          e1;
    logic [NCH-1:0]          busy;
    logic [NCH-1:0]          hit_int;
    logic                    strobe_q;
    logic [DAC_W-1:0]        d0;
    logic [SUM_W-1:0]        inj_sum [NCH];
    logic [CMP_W-1:0]        inj_shr [NCH];
    logic [TOT_W-1:0]        inj     [NCH];
    logic [TOT_W-1:0]        cnt_q   [NCH];
    logic [TOT_W-1:0]        cnt_d   [NCH];
`ifdef AFE_TOT_PILEUP_EN
    logic [TOT_W:0]          pile    [NCH];
`endif
    logic [DELAY_STAGES-1:0] dly_q;

    assign e0 = S0 & ~s0_q;
    assign e1 = S1 & ~s1_q;
    assign d0 = (CAL_HI > CAL_MI) ? CAL_HI - CAL_MI : '0;

    // Injected ToT: both amplitude terms sum before the discharge shift, then saturate.
    always_comb begin : inj_calc
        for (int i = 0; i < NCH; i++) begin
            inj_sum[i] = (e0[i] ? SUM_W'(d0) : '0) + (e1[i] ? SUM_W'(CAL_MI) : '0);
            inj_shr[i] = CMP_W'(inj_sum[i] >> IDISCH_SHIFT);
            inj[i]     = (inj_shr[i] > CMP_W'(TOT_MAX)) ? TOT_MAX : TOT_W'(inj_shr[i]);
        end
    end

    always_comb begin : cnt_next
        busy    = '0;
        hit_int = '0;
        for (int i = 0; i < NCH; i++) begin
            busy[i]    = (cnt_q[i] != '0);
            hit_int[i] = (PIXEL_IN[i] | busy[i]) & ~POWER_DOWN[i];
`ifdef AFE_TOT_PILEUP_EN
            pile[i]    = {1'b0, cnt_q[i]} + {1'b0, inj[i]};
`endif
            cnt_d[i]   = cnt_q[i];
            if (POWER_DOWN[i]) begin
                cnt_d[i] = '0;
            end else if (inj[i] != '0 && !busy[i]) begin
                cnt_d[i] = inj[i];
`ifdef AFE_TOT_PILEUP_EN
            end else if (inj[i] != '0) begin
                cnt_d[i] = pile[i][TOT_W] ? TOT_MAX : pile[i][TOT_W-1:0];
`endif
            end else if (busy[i]) begin
                cnt_d[i] = cnt_q[i] - TOT_W'(1);
            end
        end
    end

    assign TOT_BUSY = busy;

    always_ff @(posedge CLK) begin : cnt_reg
        for (int i = 0; i < NCH; i++) begin
            if (RESET) cnt_q[i] <= '0;
            else       cnt_q[i] <= cnt_d[i];
        end
    end

    // Edge-detect history follows S even in reset, so a level held through reset is not an edge.
    always_ff @(posedge CLK) begin : edge_reg
        s0_q <= S0;
        s1_q <= S1;
    end

    // Latch: capture on the strobe rising edge, hold while high, blank when low or in autozero.
    always_ff @(posedge CLK) begin : latch_reg
        if (RESET) begin
            strobe_q <= 1'b0;
            VOUTP    <= '1;
            VOUTN    <= '1;
        end else begin
            strobe_q <= STROBE;
            if (!STROBE || PHI_AZ) begin
                VOUTP <= '1;
                VOUTN <= '1;
            end else if (!strobe_q) begin
                VOUTP <= ~hit_int | POWER_DOWN;
                VOUTN <= hit_int | POWER_DOWN;
            end else begin
                VOUTP <= VOUTP | POWER_DOWN;
                VOUTN <= VOUTN | POWER_DOWN;
            end
        end
    end

    always_ff @(posedge CLK) begin : delay_reg
        if (RESET) dly_q <= '0;
        else       dly_q <= DELAY_STAGES'({dly_q, DELAY_IN});
    end

    assign DELAY_OUT = ~dly_q[DELAY_STAGES-1];

endmodule

// File: tb/tb_rd53_afe_tot_array.sv
// Self-checking bench for rd53_afe_tot_array: directed scenarios plus randomized traffic vs a cycle model.
module tb_rd53_afe_tot_array;

    localparam int NCH     = 8;
    localparam int DAC_W   = 12;
    localparam int TOT_W   = 8;
    localparam int DS      = 2;
    localparam int TOT_MAX = (1 << TOT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   pixel_in, s0, s1, power_down;
    logic [DAC_W-1:0] cal_hi, cal_mi;
    logic [2:0]       idisch_shift;
    logic             phi_az, strobe, delay_in;
    logic             delay_out;
    logic [NCH-1:0]   voutp, voutn, tot_busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int             m_cnt [NCH];
    logic [NCH-1:0] m_s0q, m_s1q, m_vp, m_vn;
    bit             m_stq;
    bit             m_dly [$];

    always #5 clk = ~clk;

    rd53_afe_tot_array #(.NCH(NCH), .DAC_W(DAC_W), .TOT_W(TOT_W), .DELAY_STAGES(DS)) dut (
        .CLK(clk), .RESET(rst), .PIXEL_IN(pixel_in), .S0(s0), .S1(s1),
        .CAL_HI(cal_hi), .CAL_MI(cal_mi), .IDISCH_SHIFT(idisch_shift),
        .POWER_DOWN(power_down), .PHI_AZ(phi_az), .STROBE(strobe),
        .DELAY_IN(delay_in), .DELAY_OUT(delay_out),
        .VOUTP(voutp), .VOUTN(voutn), .TOT_BUSY(tot_busy)
    );

    function automatic logic [NCH-1:0] model_busy();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = (m_cnt[i] != 0);
        return r;
    endfunction

    // One clock: model computes next state from current inputs, DUT clocks, then settle 1 time unit.
    task automatic step();
        int             nxt [NCH];
        logic [NCH-1:0] nvp, nvn;
        int             d0, nw;
        bit             e0, e1, hit;
        d0 = (cal_hi > cal_mi) ? int'(cal_hi) - int'(cal_mi) : 0;
        for (int i = 0; i < NCH; i++) begin
            e0  = s0[i] && !m_s0q[i];
            e1  = s1[i] && !m_s1q[i];
            nw  = ((e0 ? d0 : 0) + (e1 ? int'(cal_mi) : 0)) >> idisch_shift;
            if (nw > TOT_MAX) nw = TOT_MAX;
            hit = (pixel_in[i] || m_cnt[i] != 0) && !power_down[i];
            if (rst || power_down[i]) nxt[i] = 0;
            else if (nw > 0 && m_cnt[i] == 0) nxt[i] = nw;
`ifdef AFE_TOT_PILEUP_EN
            else if (nw > 0) nxt[i] = (m_cnt[i] + nw > TOT_MAX) ? TOT_MAX : m_cnt[i] + nw;
`endif
            else nxt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            if (rst || power_down[i] || !strobe || phi_az) begin
                nvp[i] = 1'b1; nvn[i] = 1'b1;
            end else if (!m_stq) begin
                nvp[i] = !hit; nvn[i] = hit;
            end else begin
                nvp[i] = m_vp[i]; nvn[i] = m_vn[i];
            end
        end
        @(posedge clk);
        for (int i = 0; i < NCH; i++) m_cnt[i] = nxt[i];
        m_vp  = nvp;
        m_vn  = nvn;
        m_s0q = s0;
        m_s1q = s1;
        m_stq = rst ? 1'b0 : strobe;
        if (rst) begin
            m_dly.delete();
            repeat (DS) m_dly.push_back(1'b0);
        end else begin
            m_dly.push_back(delay_in);
            void'(m_dly.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (tot_busy !== '0) begin errors++; $display("FAIL reset_busy: got %h want 00", tot_busy); end
        checks++; if (voutp !== '1) begin errors++; $display("FAIL reset_voutp: got %h want ff", voutp); end
        checks++; if (voutn !== '1) begin errors++; $display("FAIL reset_voutn: got %h want ff", voutn); end
        checks++; if (delay_out !== 1'b1) begin errors++; $display("FAIL reset_delay_out: got %b want 1", delay_out); end
        rst = 1'b0;
        step();
    endtask

    // (500-50)>>2 = 112 cycles of busy on ch0 only.
    task automatic test_inject_basic();
        int len = 0, others = 0, mism = 0;
        cal_hi = 12'd500; cal_mi = 12'd50; idisch_shift = 3'd2;
        s0 = NCH'(1);
        step();
        s0 = '0;
        for (int k = 0; k < 300 && tot_busy[0] === 1'b1; k++) begin
            len++;
            if (tot_busy[NCH-1:1] !== '0) others++;
            if (tot_busy !== model_busy()) mism++;
            step();
        end
        checks++; if (len != 112) begin errors++; $display("FAIL inject_len: got %0d want 112", len); end
        checks++; if (others != 0) begin errors++; $display("FAIL inject_others_idle: got %0d busy cycles want 0", others); end
        checks++; if (mism != 0) begin errors++; $display("FAIL inject_model: got %0d mismatching cycles want 0", mism); end
    endtask

    // 4095 from S0 plus 0 from S1, no shift, saturates to 255.
    task automatic test_saturate();
        int len = 0;
        cal_hi = 12'd4095; cal_mi = 12'd0; idisch_shift = 3'd0;
        s0 = NCH'(8); s1 = NCH'(8);
        step();
        s0 = '0; s1 = '0;
        for (int k = 0; k < 400 && tot_busy[3] === 1'b1; k++) begin
            len++;
            step();
        end
        checks++; if (len != 255) begin errors++; $display("FAIL saturate_len: got %0d want 255", len); end
    endtask

    task automatic test_strobe();
        cal_hi = 12'd500; cal_mi = 12'd50; idisch_shift = 3'd2;
        s0 = NCH'(1);
        step();
        s0 = '0;
        strobe = 1'b1;
        step();
        checks++; if (voutp !== 8'hfe || voutn !== 8'h01) begin errors++; $display("FAIL strobe_capture: got %h/%h want fe/01", voutp, voutn); end
        pixel_in = 8'hf0;
        step();
        checks++; if (voutp !== 8'hfe || voutn !== 8'h01) begin errors++; $display("FAIL strobe_hold: got %h/%h want fe/01", voutp, voutn); end
        strobe = 1'b0;
        step();
        checks++; if (voutp !== 8'hff || voutn !== 8'hff) begin errors++; $display("FAIL strobe_release: got %h/%h want ff/ff", voutp, voutn); end
        phi_az = 1'b1; strobe = 1'b1;
        step();
        checks++; if (voutp !== 8'hff || voutn !== 8'hff) begin errors++; $display("FAIL strobe_autozero: got %h/%h want ff/ff", voutp, voutn); end
        phi_az = 1'b0;
        step();
        checks++; if (voutp !== 8'hff || voutn !== 8'hff) begin errors++; $display("FAIL strobe_no_late_edge: got %h/%h want ff/ff", voutp, voutn); end
        strobe = 1'b0; pixel_in = '0;
        step();
        for (int k = 0; k < 1000 && tot_busy !== '0; k++) step();
    endtask

    // Second edge seen when ch0 holds 92: pile-up gives 21 + 204 busy cycles, otherwise 112.
    task automatic test_pileup();
        int len = 0, mism = 0, want;
`ifdef AFE_TOT_PILEUP_EN
        want = 21 + 204;
`else
        want = 112;
`endif
        cal_hi = 12'd500; cal_mi = 12'd50; idisch_shift = 3'd2;
        s0 = NCH'(1);
        step();
        for (int k = 0; k < 700; k++) begin
            if (tot_busy[0] === 1'b1) len++;
            if (tot_busy !== model_busy()) mism++;
            s0 = (k == 20) ? NCH'(1) : '0;
            step();
        end
        checks++; if (len != want) begin errors++; $display("FAIL pileup_len: got %0d want %0d", len, want); end
        checks++; if (mism != 0) begin errors++; $display("FAIL pileup_model: got %0d mismatching cycles want 0", mism); end
    endtask

    task automatic test_reset_mid();
        int residual = 0;
        cal_hi = 12'd500; cal_mi = 12'd50; idisch_shift = 3'd2;
        s0 = NCH'(1);
        step();
        repeat (62) step();
        checks++; if (tot_busy[0] !== 1'b1) begin errors++; $display("FAIL resetmid_busy_before: got %b want 1", tot_busy[0]); end
        rst = 1'b1;
        step();
        checks++; if (tot_busy !== '0 || voutp !== '1 || voutn !== '1 || delay_out !== 1'b1)
            begin errors++; $display("FAIL resetmid_state: got busy=%h vp=%h vn=%h dout=%b want 00 ff ff 1", tot_busy, voutp, voutn, delay_out); end
        rst = 1'b0;
        for (int k = 0; k < 150; k++) begin
            step();
            if (tot_busy !== '0) residual++;
        end
        checks++; if (residual != 0) begin errors++; $display("FAIL resetmid_residual: got %0d busy cycles want 0", residual); end
        s0 = '0;
        step();
    endtask

    task automatic test_delay_pd();
        delay_in = 1'b0;
        step(); step();
        delay_in = 1'b1;
        step();
        checks++; if (delay_out !== 1'b1) begin errors++; $display("FAIL delay_one_cycle: got %b want 1", delay_out); end
        step();
        checks++; if (delay_out !== 1'b0) begin errors++; $display("FAIL delay_two_cycles: got %b want 0", delay_out); end
        delay_in = 1'b0;
        step(); step();
        checks++; if (delay_out !== 1'b1) begin errors++; $display("FAIL delay_return: got %b want 1", delay_out); end
        cal_hi = 12'd500; cal_mi = 12'd50; idisch_shift = 3'd2;
        power_down = NCH'(2); s0 = NCH'(2); pixel_in = NCH'(2); strobe = 1'b1;
        step();
        checks++; if (tot_busy[1] !== 1'b0) begin errors++; $display("FAIL pd_busy: got %b want 0", tot_busy[1]); end
        checks++; if (voutp[1] !== 1'b1 || voutn[1] !== 1'b1) begin errors++; $display("FAIL pd_latch: got %b/%b want 1/1", voutp[1], voutn[1]); end
        s0 = '0; pixel_in = '0; strobe = 1'b0; power_down = '0;
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            rst          = ($urandom_range(0, 299) == 0);
            pixel_in     = NCH'($urandom & $urandom & $urandom);
            s0           = NCH'($urandom & $urandom);
            s1           = NCH'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) begin
                cal_hi       = DAC_W'($urandom);
                cal_mi       = DAC_W'($urandom_range(0, 1500));
                idisch_shift = 3'($urandom_range(0, 7));
            end
            power_down   = ($urandom_range(0, 7) == 0) ? NCH'($urandom & $urandom) : '0;
            phi_az       = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) strobe = ~strobe;
            delay_in     = 1'($urandom);
            step();
            checks++; if (tot_busy !== model_busy()) begin errors++; if (errors < 20) $display("FAIL rand_busy @%0d: got %h want %h", k, tot_busy, model_busy()); end
            checks++; if (voutp !== m_vp) begin errors++; if (errors < 20) $display("FAIL rand_voutp @%0d: got %h want %h", k, voutp, m_vp); end
            checks++; if (voutn !== m_vn) begin errors++; if (errors < 20) $display("FAIL rand_voutn @%0d: got %h want %h", k, voutn, m_vn); end
            checks++; if (delay_out !== !m_dly[0]) begin errors++; if (errors < 20) $display("FAIL rand_delay @%0d: got %b want %b", k, delay_out, !m_dly[0]); end
        end
    endtask

    initial begin
        rst = 1'b1; pixel_in = '0; s0 = '0; s1 = '0; power_down = '0;
        cal_hi = '0; cal_mi = '0; idisch_shift = '0;
        phi_az = 1'b0; strobe = 1'b0; delay_in = 1'b0;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
        m_s0q = '0; m_s1q = '0; m_vp = '1; m_vn = '1; m_stq = 1'b0;
        repeat (DS) m_dly.push_back(1'b0);
        test_reset();
        test_inject_basic();
        test_saturate();
        test_strobe();
        test_pileup();
        test_reset_mid();
        test_delay_pd();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
